// File: rtl/memory_stage.sv
// memory_stage: RV32I load/store stage over a req/gnt/rvalid data port, with
// single-cycle pass-through of non-memory ops and a registered writeback result.
module memory_stage #(
    parameter int RD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        wb_fault
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic [31:0] tmo_q;

    logic        mem_op, fault_d, tmo_hit;
    logic [1:0]  a, size;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, load_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;

    assign ex_ready = rst && state_q == IDLE;
    assign a        = ex_alu_result[1:0];
    assign size     = ex_funct3[1:0];
    assign mem_op   = ex_mem_read || ex_mem_write;
    assign fault_d  = mem_op && ((ex_mem_read && ex_mem_write) || ex_funct3 == 3'b011 ||
                      ex_funct3[2:1] == 2'b11 || (size == 2'b01 && a[0]) ||
                      (size == 2'b10 && a != 2'b00));
    assign be_d     = size == 2'b00 ? 4'b0001 << a :
                      size == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    assign wdata_d  = size == 2'b00 ? {4{ex_rs2_data[7:0]}} :
                      size == 2'b01 ? {2{ex_rs2_data[15:0]}} : ex_rs2_data;
    // Lane select uses the byte offset latched at issue; funct3[2] means zero-extend.
    assign byte_d   = dmem_rdata[{lane_q, 3'b000} +: 8];
    assign half_d   = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
    assign load_d   = funct3_q[1:0] == 2'b00 ? {{24{!funct3_q[2] && byte_d[7]}}, byte_d} :
                      funct3_q[1:0] == 2'b01 ? {{16{!funct3_q[2] && half_d[15]}}, half_d} :
                      dmem_rdata;
    assign tmo_hit  = RD_TIMEOUT != 0 && tmo_q == 32'(RD_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            funct3_q     <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            tmo_q        <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            wb_fault     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state_q)
                IDLE: if (ex_valid) begin
                    if (!mem_op || fault_d) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_alu_result;
                        wb_rd        <= ex_rd;
                        wb_reg_write <= ex_reg_write && !mem_op;
                        wb_fault     <= fault_d;
                    end else begin
                        state_q    <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_write;
                        dmem_addr  <= {ex_alu_result[31:2], 2'b00};
                        dmem_be    <= be_d;
                        dmem_wdata <= wdata_d;
                        lane_q     <= a;
                        funct3_q   <= ex_funct3;
                        rd_q       <= ex_rd;
                        rw_q       <= ex_reg_write;
                    end
                end
                REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    dmem_be  <= '0;
                    tmo_q    <= '0;
                    if (dmem_we) begin
                        state_q      <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_data      <= {dmem_addr[31:2], lane_q};
                        wb_rd        <= rd_q;
                        wb_reg_write <= 1'b0;
                        wb_fault     <= 1'b0;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    tmo_q <= tmo_q + 32'd1;
                    if (dmem_rvalid || tmo_hit) begin
                        state_q      <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_data      <= dmem_rvalid ? load_d : 32'd0;
                        wb_rd        <= rd_q;
                        wb_reg_write <= dmem_rvalid && rw_q;
                        wb_fault     <= !dmem_rvalid;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and randomized checks of memory_stage against an
// arithmetic reference model of the load/store rules.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_ready;
    logic [31:0] ex_alu_result = '0, ex_rs2_data = '0;
    logic [2:0]  ex_funct3 = '0;
    logic        ex_mem_read = 1'b0, ex_mem_write = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_reg_write, wb_fault;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int passed = 0;
    int total  = 0;

    memory_stage #(.RD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data), .ex_funct3(ex_funct3),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw);
        @(negedge clk);
        check("wb_pulse_low", wb_valid, 1'b0);
        check("ready_idle", ex_ready, 1'b1);
        ex_valid = 1'b1; ex_mem_read = r; ex_mem_write = w; ex_funct3 = f3;
        ex_alu_result = a; ex_rs2_data = d; ex_rd = rd; ex_reg_write = rw;
        dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom);
        @(negedge clk);
        ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    // One full op: issue, serve memory with gd gnt-wait and vd rvalid-wait cycles, check wb.
    task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic rw,
                         input int gd, input int vd, input logic [31:0] rdat);
        int nb;
        logic flt, mem;
        logic [3:0] be;
        logic [31:0] wd, ld;
        longint m, v;
        nb  = 1 << f3[1:0];
        mem = r || w;
        flt = mem && ((r && w) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (a % nb) != 0);
        be  = 4'(((1 << nb) - 1) << (a % 4));
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = d[8*(i % nb) +: 8];
        m = (64'sd1 << (8 * nb)) - 1;
        v = (longint'({32'd0, rdat}) >> (8 * (a % 4))) & m;
        if (!f3[2] && v > m / 2) v = v - (m + 1);
        ld = 32'(v);
        issue(r, w, f3, a, d, rd, rw);
        if (!mem || flt) begin
            check("pt_valid", wb_valid, 1'b1);
            check("pt_data", wb_data, a);
            check("pt_rd", wb_rd, rd);
            check("pt_rw", wb_reg_write, mem ? 1'b0 : rw);
            check("pt_fault", wb_fault, flt);
            check("pt_noreq", dmem_req, 1'b0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                check("req_held", dmem_req, 1'b1);
                check("req_we", dmem_we, w);
                check("req_addr", dmem_addr, {a[31:2], 2'b00});
                check("req_be", dmem_be, be);
                if (w) check("req_wdata", dmem_wdata, wd);
                check("req_busy", ex_ready, 1'b0);
                check("req_nowb", wb_valid, 1'b0);
                if (i == gd) dmem_gnt = 1'b1;
                @(negedge clk);
            end
            dmem_gnt = 1'b0;
            check("gnt_reqdrop", dmem_req, 1'b0);
            if (w) begin
                check("st_valid", wb_valid, 1'b1);
                check("st_rw", wb_reg_write, 1'b0);
                check("st_fault", wb_fault, 1'b0);
                check("st_rd", wb_rd, rd);
            end else begin
                check("ld_wait", wb_valid, 1'b0);
                repeat (vd) begin
                    dmem_gnt = 1'($urandom);
                    @(negedge clk);
                    dmem_gnt = 1'b0;
                    check("ld_wait", wb_valid, 1'b0);
                end
                dmem_rvalid = 1'b1; dmem_rdata = rdat;
                @(negedge clk);
                dmem_rvalid = 1'b0; dmem_rdata = $urandom;
                check("ld_valid", wb_valid, 1'b1);
                check("ld_data", wb_data, ld);
                check("ld_rw", wb_reg_write, rw);
                check("ld_fault", wb_fault, 1'b0);
                check("ld_rd", wb_rd, rd);
            end
        end
    endtask

    initial begin
        logic [2:0] f3;
        logic r, w;
        logic [31:0] a;
        repeat (2) @(negedge clk);
        check("rst_ready", ex_ready, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_be", dmem_be, 4'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wbv", wb_valid, 1'b0);
        check("rst_wbdata", wb_data, 32'd0);
        check("rst_wbrd", wb_rd, 5'd0);
        check("rst_fault", wb_fault, 1'b0);
        rst = 1'b1;

        do_op(0, 0, 3'd0, 32'h1234_5678, 32'd0, 5'd5, 1, 0, 0, 32'd0);
        do_op(0, 1, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 0, 0, 0, 32'd0);
        do_op(1, 0, 3'd0, 32'h0000_0102, 32'd0, 5'd7, 1, 3, 0, 32'h0080_0000);
        check("lb_value", wb_data, 32'hFFFF_FF80);
        do_op(1, 0, 3'd4, 32'h0000_0102, 32'd0, 5'd7, 1, 3, 0, 32'h0080_0000);
        check("lbu_value", wb_data, 32'h0000_0080);
        do_op(1, 0, 3'd2, 32'h0000_0106, 32'd0, 5'd9, 1, 0, 0, 32'd0);
        check("lw_mis_fault", wb_fault, 1'b1);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: begin r = 0; w = 0; f3 = 3'($urandom); end
                1: begin r = 1; w = 0; f3 = 3'($urandom); end
                2: begin r = 0; w = 1; f3 = 3'($urandom_range(0, 2)); end
                default: begin r = 1'($urandom); w = 1'($urandom); f3 = 3'($urandom); end
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(r, w, f3, a, $urandom, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        issue(1, 0, 3'd2, 32'h0000_0040, 32'd0, 5'd3, 1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) check("tmo_wait", wb_valid, 1'b0);
        end
        check("tmo_valid", wb_valid, 1'b1);
        check("tmo_fault", wb_fault, 1'b1);
        check("tmo_data", wb_data, 32'd0);
        check("tmo_rw", wb_reg_write, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("tmo_stray", wb_valid, 1'b0);
        check("tmo_ready", ex_ready, 1'b1);

        issue(1, 0, 3'd2, 32'h0000_0200, 32'd0, 5'd4, 1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        check("rstr_req", dmem_req, 1'b0);
        check("rstr_wbv", wb_valid, 1'b0);
        check("rstr_ready", ex_ready, 1'b0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0; rst = 1'b1;
        check("rstr_nowb", wb_valid, 1'b0);
        @(negedge clk);
        check("rstr_idle", ex_ready, 1'b1);
        check("rstr_nowb2", wb_valid, 1'b0);

        issue(0, 1, 3'd2, 32'h0000_0300, 32'h5555_AAAA, 5'd1, 0);
        check("rstq_req", dmem_req, 1'b1);
        rst = 1'b0;
        #1;
        check("rstq_drop", dmem_req, 1'b0);
        check("rstq_be", dmem_be, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        do_op(0, 0, 3'd0, 32'hCAFE_F00D, 32'd0, 5'd31, 1, 0, 0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
